ldm_stm_seq: RTL and testbench

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

---
 rtl/leg_ldm_pkg.sv | 37 +++
 rtl/countones.sv | 16 +
 rtl/lsb_find.sv | 16 +
 rtl/ldm_stm_seq.sv | 124 ++++++++++++
 tb/tb_ldm_stm_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leg_ldm_pkg.sv
// leg_ldm_pkg: shared types and constants for the LDM/STM micro-op sequencer
package leg_ldm_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB,
        DONE
    } state_t;

    // Encoding matches {p_bit, u_bit} so the mode is a direct cast of the two bits.
    typedef enum logic [1:0] {
        DA = 2'b00,
        IA = 2'b01,
        DB = 2'b10,
        IB = 2'b11
    } mode_t;

    // Byte span covered by n words.
    function automatic logic [31:0] word_span(input logic [4:0] n);
        return 32'(n) * 32'(WORD_BYTES);
    endfunction

    // Lowest transfer address; transfers always walk upwards from here.
    function automatic logic [31:0] first_addr(input mode_t m, input logic [31:0] b,
                                               input logic [4:0] n);
        logic [31:0] step;
        step = 32'(WORD_BYTES);
        return (m == IA) ? b :
               (m == IB) ? b + step :
               (m == DA) ? b - word_span(n) + step :
                           b - word_span(n);
    endfunction

endpackage

// File: rtl/countones.sv
// countones: population count of a W-bit vector
module countones #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Sum the set bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) cnt = cnt + CW'(din[i]);
    end

endmodule

// File: rtl/lsb_find.sv
// lsb_find: lowest-set-bit priority encoder for a 16-bit register list
module lsb_find (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) if (vec[i]) idx = 4'(i);
    end

    assign any = |vec;

endmodule

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: expands an LDM/STM block transfer into per-register micro-ops
module ldm_stm_seq
    import leg_ldm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        start_ready,
    input  logic [15:0] reglist,
    input  logic [31:0] base,
    input  logic        p_bit,
    input  logic        u_bit,
    input  logic        w_bit,
    input  logic        l_bit,
    input  logic        flush,
    input  logic        uop_ready,
    output logic        uop_valid,
    output logic [3:0]  uop_reg,
    output logic [31:0] uop_addr,
    output logic        uop_load,
    output logic        wb_valid,
    output logic [31:0] wb_value,
    output logic        done
);

    state_t      state_q, state_d;
    logic [15:0] list_q, list_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] base_q, base_d;
    logic [4:0]  n_q, n_d;
    logic        u_q, u_d;
    logic        w_q, w_d;
    logic        l_q, l_d;

    logic [4:0]  n_new;
    logic [3:0]  idx;
    logic        any;
    logic [15:0] remaining;
    logic        hs;

    countones #(.W(16)) u_count (
        .din (reglist),
        .cnt (n_new)
    );

    lsb_find u_lsb (
        .vec (list_q),
        .idx (idx),
        .any (any)
    );

    assign start_ready = state_q == IDLE;
    assign uop_valid   = (state_q == XFER) && any;
    assign uop_reg     = uop_valid ? idx : 4'd0;
    assign uop_addr    = uop_valid ? addr_q : 32'd0;
    assign uop_load    = uop_valid & l_q;
    assign wb_valid    = state_q == WB;
    assign wb_value    = wb_valid ? (u_q ? base_q + word_span(n_q) : base_q - word_span(n_q)) : 32'd0;
    assign done        = state_q == DONE;
    assign hs          = uop_valid && uop_ready;
    assign remaining   = list_q & ~(16'd1 << idx);

    // Next-state and working-register updates; flush overrides everything.
    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        addr_d  = addr_q;
        base_d  = base_q;
        n_d     = n_q;
        u_d     = u_q;
        w_d     = w_q;
        l_d     = l_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    list_d  = reglist;
                    base_d  = base;
                    n_d     = n_new;
                    u_d     = u_bit;
                    w_d     = w_bit;
                    l_d     = l_bit;
                    addr_d  = first_addr(mode_t'({p_bit, u_bit}), base, n_new);
                    state_d = (n_new == 5'd0) ? DONE : XFER;
                end
                XFER: if (hs) begin
                    list_d  = remaining;
                    addr_d  = addr_q + 32'(WORD_BYTES);
                    state_d = (remaining != 16'd0) ? XFER : (w_q ? WB : DONE);
                end else if (!any) begin
                    state_d = IDLE;
                end
                WB:      state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and latched transfer context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            list_q  <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            n_q     <= '0;
            u_q     <= 1'b0;
            w_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            n_q     <= n_d;
            u_q     <= u_d;
            w_q     <= w_d;
            l_q     <= l_d;
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: scoreboard bench for the LDM/STM micro-op sequencer
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_ready;
    logic [15:0] reglist = '0;
    logic [31:0] base = '0;
    logic        p_bit = 1'b0, u_bit = 1'b0, w_bit = 1'b0, l_bit = 1'b0;
    logic        flush = 1'b0;
    logic        uop_ready = 1'b1;
    logic        uop_valid;
    logic [3:0]  uop_reg;
    logic [31:0] uop_addr;
    logic        uop_load;
    logic        wb_valid;
    logic [31:0] wb_value;
    logic        done;

    ldm_stm_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_ready (start_ready),
        .reglist     (reglist),
        .base        (base),
        .p_bit       (p_bit),
        .u_bit       (u_bit),
        .w_bit       (w_bit),
        .l_bit       (l_bit),
        .flush       (flush),
        .uop_ready   (uop_ready),
        .uop_valid   (uop_valid),
        .uop_reg     (uop_reg),
        .uop_addr    (uop_addr),
        .uop_load    (uop_load),
        .wb_valid    (wb_valid),
        .wb_value    (wb_value),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
        logic        l;
    } uop_t;

    uop_t        uq[$];
    logic [31:0] wq[$];
    int          dq[$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int cyc = 0;
    int stall_until = 0;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the expected micro-op stream from the addressing rules.
    task automatic model(input logic [15:0] rl, input logic [31:0] b,
                         input logic p, input logic u, input logic w, input logic l);
        int          n;
        logic [31:0] a;
        uop_t        e;
        n = $countones(rl);
        if (u) a = p ? b + 4 : b;
        else   a = p ? b - 32'(4 * n) : b - 32'(4 * n) + 4;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                e.r = 4'(i);
                e.a = a;
                e.l = l;
                uq.push_back(e);
                a = a + 4;
            end
        end
        if (w && n > 0) wq.push_back(u ? b + 32'(4 * n) : b - 32'(4 * n));
        dq.push_back(n);
    endtask

    // uop_ready driver: optional directed stall window, otherwise random or always-ready.
    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        uop_ready = (cyc < stall_until) ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    logic        hold_v = 1'b0;
    logic [3:0]  hold_r;
    logic [31:0] hold_a;
    logic        hold_l;

    // Monitor: pops expectations whenever the DUT presents a handshake, writeback or done.
    always @(negedge clk) begin
        if (!reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && uop_valid) begin
                chk("stall_hold_reg", uop_reg, hold_r);
                chk("stall_hold_addr", uop_addr, hold_a);
                chk("stall_hold_load", uop_load, hold_l);
            end
            hold_v = 1'b0;
            if (uop_valid) begin
                chk("busy_start_ready", start_ready, 0);
                if (!uop_ready) begin
                    stall_cnt++;
                    hold_v = 1'b1;
                    hold_r = uop_reg;
                    hold_a = uop_addr;
                    hold_l = uop_load;
                end else if (uq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL uop_unexpected: got r%0d at %0h expected none", uop_reg, uop_addr);
                end else begin
                    uop_t e;
                    e = uq.pop_front();
                    chk("uop_reg", uop_reg, e.r);
                    chk("uop_addr", uop_addr, e.a);
                    chk("uop_load", uop_load, e.l);
                end
            end else begin
                chk("idle_uop_reg", uop_reg, 0);
                chk("idle_uop_addr", uop_addr, 0);
            end
            if (wb_valid) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got %0h expected none", wb_value);
                end else begin
                    chk("wb_value", wb_value, wq.pop_front());
                    chk("wb_after_uops", uq.size(), 0);
                end
            end else begin
                chk("idle_wb_value", wb_value, 0);
            end
            if (done) begin
                done_cnt++;
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got 1 expected 0");
                end else begin
                    void'(dq.pop_front());
                    chk("done_after_all", uq.size() + wq.size(), 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_uop_valid"}, uop_valid, 0);
        chk({tag, "_uop_reg"}, uop_reg, 0);
        chk({tag, "_uop_addr"}, uop_addr, 0);
        chk({tag, "_uop_load"}, uop_load, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_value"}, wb_value, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic issue(input logic [15:0] rl, input logic [31:0] b,
                         input logic p, input logic u, input logic w, input logic l);
        model(rl, b, p, u, w, l);
        reglist = rl;
        base    = b;
        p_bit   = p;
        u_bit   = u;
        w_bit   = w;
        l_bit   = l;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Bounded wait for the done pulse; returns cycles after the accepting edge.
    task automatic wait_done(input int tgt, output int k);
        k = 0;
        while (done_cnt < tgt && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cnt < tgt) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, tgt);
        end
    endtask

    initial begin
        int d;
        int k;
        logic [15:0] rl;
        d = 0;
        #1 reset = 1'b0;
        #1 check_reset_outputs("reset");
        #1 reset = 1'b1;

        issue(16'h00F0, 32'h0000_1000, 0, 1, 1, 1);
        wait_done(++d, k);
        chk("ia_wb_latency", k, 6);

        issue(16'hC001, 32'h0000_2000, 1, 0, 0, 0);
        wait_done(++d, k);
        chk("db_latency", k, 4);

        stall_cnt   = 0;
        stall_until = cyc + 5;
        issue(16'h0006, 32'h0, 1, 1, 0, 1);
        wait_done(++d, k);
        chk("bp_stall_cycles", stall_cnt, 3);
        chk("bp_latency", k, 6);

        issue(16'h0000, 32'h0000_5000, 0, 1, 1, 1);
        wait_done(++d, k);
        chk("empty_latency", k, 1);

        issue(16'h0003, 32'h0, 0, 0, 1, 1);
        wait_done(++d, k);
        chk("da_wrap_latency", k, 4);

        rand_ready = 1'b1;
        repeat (40) begin
            case ($urandom_range(0, 5))
                0:       rl = 16'h0000;
                1:       rl = 16'hFFFF;
                2:       rl = 16'd1 << $urandom_range(0, 15);
                default: rl = 16'($urandom);
            endcase
            issue(rl, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            wait_done(++d, k);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        issue(16'h8421, 32'h0000_3000, 0, 1, 1, 1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle", start_ready, 1);
        chk("flush_no_uop", uop_valid, 0);
        uq.delete();
        wq.delete();
        dq.delete();
        reglist = 16'h0001;
        start   = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_ignored", start_ready, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("flush_no_done", done_cnt, d);

        stall_until = cyc + 100;
        issue(16'h00FF, 32'h0000_4000, 0, 1, 1, 1);
        chk("pre_reset_valid", uop_valid, 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        uq.delete();
        wq.delete();
        dq.delete();
        stall_until = 0;
        @(posedge clk);
        #1 reset = 1'b1;

        issue(16'h0011, 32'h0000_0010, 0, 1, 0, 0);
        wait_done(++d, k);
        chk("post_reset_latency", k, 3);

        repeat (2) @(posedge clk);
        chk("uop_queue_drained", uq.size(), 0);
        chk("wb_queue_drained", wq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
